// File: rtl/tsc_pkg.sv
// Shared types and constants for the timestamp capture array.
// Channel FSM encoding, miss-counter width, default sizing and capture-skew helper.
package tsc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } chan_state_e;

    localparam int MISS_W       = 8;
    localparam int DEF_WIDTH    = 64;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_SYNC     = 2;

    // Cycles from event pin to the captured timebase value.
    function automatic int capture_skew(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/tsc_channel.sv
// One capture channel: synchroniser, edge detector, IDLE/HELD FSM, overrun flag.
// The dropped-edge counter exists only when TSC_MISS_COUNT_EN is defined.
module tsc_channel
    import tsc_pkg::*;
#(
    parameter int pWIDTH = DEF_WIDTH,
    parameter int pSYNC  = DEF_SYNC
) (
    input  logic              globalClock,
    input  logic              iReset_n,
    input  logic              iEvent,
    input  logic              iAck,
    input  logic [pWIDTH-1:0] iCount,
    output logic [pWIDTH-1:0] oTimestamp,
    output logic              oReady,
    output logic              oOverrun,
    output logic [MISS_W-1:0] oMissCount
);

    logic [pSYNC-1:0]  sync_q;
    logic              prev_q;
    logic              edge_q;
    chan_state_e       state_q;
    logic [pWIDTH-1:0] ts_q;
    logic              ovr_q;

    // Synchroniser chain followed by a registered rising-edge detector.
    always_ff @(posedge globalClock or negedge iReset_n) begin
        if (!iReset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[pSYNC-2:0], iEvent};
            prev_q <= sync_q[pSYNC-1];
            edge_q <= sync_q[pSYNC-1] & ~prev_q;
        end
    end

    // Channel FSM with capture register and sticky overrun flag.
    always_ff @(posedge globalClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (edge_q) begin
                        ts_q    <= iCount;
                        state_q <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (iAck) begin
                        ovr_q <= 1'b0;
                        if (edge_q) begin
                            ts_q <= iCount;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (edge_q) begin
                        ovr_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ovr_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TSC_MISS_COUNT_EN
    logic [MISS_W-1:0] miss_q;

    // Saturating count of edges dropped while holding; cleared by acknowledge.
    always_ff @(posedge globalClock or negedge iReset_n) begin
        if (!iReset_n) begin
            miss_q <= '0;
        end else if (state_q == ST_HELD && iAck) begin
            miss_q <= '0;
        end else if (state_q == ST_HELD && edge_q && miss_q != {MISS_W{1'b1}}) begin
            miss_q <= miss_q + {{(MISS_W-1){1'b0}}, 1'b1};
        end
    end

    assign oMissCount = miss_q;
`else
    assign oMissCount = '0;
`endif

    assign oTimestamp = ts_q;
    assign oReady     = (state_q == ST_HELD);
    assign oOverrun   = ovr_q;

endmodule

// File: rtl/timestamp_capture_array.sv
// Shared free-running timebase feeding pCHANNELS independent capture channels.
// Optional per-channel dropped-edge counters: define TSC_MISS_COUNT_EN.
module timestamp_capture_array
    import tsc_pkg::*;
#(
    parameter int pWIDTH    = DEF_WIDTH,
    parameter int pCHANNELS = DEF_CHANNELS,
    parameter int pSYNC     = DEF_SYNC
) (
    input  logic                          globalClock,
    input  logic                          iReset_n,
    input  logic                          iEnable,
    input  logic                          iClear,
    input  logic [pCHANNELS-1:0]          iEvent,
    input  logic [pCHANNELS-1:0]          iAck,
    output logic [pCHANNELS*pWIDTH-1:0]   oTimestamp,
    output logic [pCHANNELS-1:0]          oReady,
    output logic [pCHANNELS-1:0]          oOverrun,
    output logic [pCHANNELS*MISS_W-1:0]   oMissCount,
    output logic                          oWrap,
    output logic [pWIDTH-1:0]             oCount
);

    logic [pWIDTH-1:0] count_q, count_d;
    logic              wrap_q, wrap_d;

    // Timebase next state: clear beats enable; wrap flagged only on a counted rollover.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (iClear) begin
            count_d = '0;
        end else if (iEnable) begin
            count_d = count_q + {{(pWIDTH-1){1'b0}}, 1'b1};
            wrap_d  = (count_q == {pWIDTH{1'b1}});
        end else begin
            count_d = count_q;
        end
    end

    // Timebase and wrap pulse registers.
    always_ff @(posedge globalClock or negedge iReset_n) begin
        if (!iReset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    for (genvar k = 0; k < pCHANNELS; k++) begin : g_chan
        tsc_channel #(
            .pWIDTH (pWIDTH),
            .pSYNC  (pSYNC)
        ) u_chan (
            .globalClock (globalClock),
            .iReset_n    (iReset_n),
            .iEvent      (iEvent[k]),
            .iAck        (iAck[k]),
            .iCount      (count_q),
            .oTimestamp  (oTimestamp[k*pWIDTH +: pWIDTH]),
            .oReady      (oReady[k]),
            .oOverrun    (oOverrun[k]),
            .oMissCount  (oMissCount[k*MISS_W +: MISS_W])
        );
    end

    assign oCount = count_q;
    assign oWrap  = wrap_q;

endmodule
